// File: rtl/flex_sr_lane_pkg.sv
// Shared types, defaults and width helper for the flex_sr_lane serialiser core.
package flex_sr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_SIZE       = 8;
    localparam int DEF_LANES      = 1;
    localparam bit DEF_RESET_ONES = 1'b1;

    function automatic int cnt_w(input int size, input int lanes);
        return $clog2(size / lanes + 1);
    endfunction

endpackage

// File: rtl/flex_sr_lane_if.sv
// Load handshake, serial and status bundle of flex_sr_lane.
// parity_out exists only when FLEX_SR_LANE_PARITY_EN is defined.
interface flex_sr_lane_if
    import flex_sr_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int LANES = DEF_LANES
) ();
    localparam int CW = cnt_w(SIZE, LANES);

    logic             load_valid;
    logic             load_ready;
    logic [SIZE-1:0]  parallel_in;
    logic             msb_first;
    logic             shift_enable;
    logic [LANES-1:0] serial_in;
    logic [LANES-1:0] serial_out;
    logic [SIZE-1:0]  parallel_out;
    logic             busy;
    logic             word_done;
    logic [CW-1:0]    count;
`ifdef FLEX_SR_LANE_PARITY_EN
    logic             parity_out;
`endif

    modport master (
        output load_valid, parallel_in, msb_first, shift_enable, serial_in,
        input
`ifdef FLEX_SR_LANE_PARITY_EN
              parity_out,
`endif
              load_ready, serial_out, parallel_out, busy, word_done, count
    );

    modport slave (
        input  load_valid, parallel_in, msb_first, shift_enable, serial_in,
        output
`ifdef FLEX_SR_LANE_PARITY_EN
               parity_out,
`endif
               load_ready, serial_out, parallel_out, busy, word_done, count
    );

endinterface

// File: rtl/flex_sr_lane_word_counter.sv
// Modulo-N shift counter; tc_o flags the last shift position of a word.
module flex_word_counter #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count_o,
    output logic         tc_o
);
    logic [W-1:0] count_q, count_d;

    assign tc_o    = (count_q == W'(N - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flex_sr_lane.sv
// Flexible multi-lane shift register with handshaked parallel load and word tracking.
// Optional running parity output under FLEX_SR_LANE_PARITY_EN.
module flex_sr_lane
    import flex_sr_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int LANES      = DEF_LANES,
    parameter bit RESET_ONES = DEF_RESET_ONES
) (
    input  logic            clk,
    input  logic            rst,
    flex_sr_lane_if.slave   bus
);
    localparam int N  = SIZE / LANES;
    localparam int CW = cnt_w(SIZE, LANES);

    if ((SIZE % LANES) != 0 || SIZE < 2 * LANES) begin : g_bad_params
        $error("flex_sr_lane: SIZE must be a multiple of LANES and >= 2*LANES");
    end

    state_t           state_q, state_d;
    logic [SIZE-1:0]  sr_q, sr_d;
    logic             dir_q, dir_d;
    logic             word_done_q, word_done_d;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             cnt_en;
    logic             final_shift;
    logic             load_acc;
    logic             cur_dir;
    logic [LANES-1:0] sout;

    // Only shifts taken in SHIFT are counted; IDLE shifting is free-running.
    assign cnt_en      = (state_q == SHIFT) && bus.shift_enable;
    assign final_shift = cnt_en && cnt_tc;
    assign load_acc    = bus.load_valid && bus.load_ready;
    assign cur_dir     = (state_q == SHIFT) ? dir_q : bus.msb_first;
    assign sout        = cur_dir ? sr_q[SIZE-1 -: LANES] : sr_q[LANES-1:0];

    assign bus.load_ready   = (state_q == IDLE) || final_shift;
    assign bus.serial_out   = sout;
    assign bus.parallel_out = sr_q;
    assign bus.busy         = (state_q == SHIFT);
    assign bus.word_done    = word_done_q;
    assign bus.count        = cnt;

    flex_word_counter #(
        .N (N),
        .W (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (cnt_en),
        .clr     (load_acc),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        dir_d       = dir_q;
        word_done_d = final_shift;

        if (load_acc) begin
            sr_d  = bus.parallel_in;
            dir_d = bus.msb_first;
        end else if (bus.shift_enable) begin
            sr_d = cur_dir ? {sr_q[SIZE-LANES-1:0], bus.serial_in}
                           : {bus.serial_in, sr_q[SIZE-1:LANES]};
        end

        case (state_q)
            IDLE:  if (bus.load_valid) state_d = SHIFT;
            SHIFT: if (final_shift && !load_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= {SIZE{RESET_ONES}};
            dir_q       <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            dir_q       <= dir_d;
            word_done_q <= word_done_d;
        end
    end

`ifdef FLEX_SR_LANE_PARITY_EN
    logic parity_q, parity_d;

    // A back-to-back load keeps the finished word's parity visible for the
    // word_done cycle; the new word starts from 0 on the following edge.
    always_comb begin
        parity_d = parity_q;
        if (load_acc && !final_shift) begin
            parity_d = 1'b0;
        end else if (cnt_en) begin
            parity_d = (word_done_q ? 1'b0 : parity_q) ^ (^sout);
        end else if (word_done_q) begin
            parity_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity_out = parity_q;
`endif

endmodule

// File: tb/tb_flex_sr_lane.sv
// Self-checking bench: two lane configurations driven together, a vector table,
// corner-case sequences and randomized traffic against a behavioural model.
module tb_flex_sr_lane;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flex_sr_lane_if #(.SIZE(8), .LANES(1)) b0 ();
    flex_sr_lane_if #(.SIZE(8), .LANES(2)) b1 ();

    flex_sr_lane #(.SIZE(8), .LANES(1), .RESET_ONES(1'b1)) u0 (
        .clk (clk), .rst (rst), .bus (b0.slave));
    flex_sr_lane #(.SIZE(8), .LANES(2), .RESET_ONES(1'b1)) u1 (
        .clk (clk), .rst (rst), .bus (b1.slave));

    int checks = 0;
    int errors = 0;

    logic       lv, msb, sh;
    logic [7:0] pin;
    logic [1:0] sin;

    // behavioural model, index 0 = one lane, index 1 = two lanes
    int mv[2];
    int mcnt[2];
    bit mbusy[2], mdir[2], mwd[2], mpar[2];

    typedef struct {
        logic       lv;
        logic [7:0] pin;
        logic       msb, sh, sin;
        logic       sout, rdy, busy, wd;
        logic [3:0] cnt;
        logic [7:0] pout;
    } vec_t;
    vec_t tbl[11];

    function automatic vec_t mk(logic l, logic [7:0] p, logic m, logic s, logic si,
                                logic so, logic r, logic b, logic w,
                                logic [3:0] c, logic [7:0] po);
        vec_t v;
        v.lv = l; v.pin = p; v.msb = m; v.sh = s; v.sin = si;
        v.sout = so; v.rdy = r; v.busy = b; v.wd = w; v.cnt = c; v.pout = po;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lanes(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int exp_sout(input int d);
        int l = lanes(d);
        bit dir = mbusy[d] ? mdir[d] : msb;
        return dir ? (mv[d] >> (8 - l)) : (mv[d] % (1 << l));
    endfunction

    function automatic bit exp_ready(input int d);
        return !mbusy[d] || (sh && mcnt[d] == 8 / lanes(d) - 1);
    endfunction

    task automatic drive();
        b0.load_valid = lv;  b1.load_valid = lv;
        b0.parallel_in = pin; b1.parallel_in = pin;
        b0.msb_first = msb;  b1.msb_first = msb;
        b0.shift_enable = sh; b1.shift_enable = sh;
        b0.serial_in = sin[0];
        b1.serial_in = sin;
    endtask

    task automatic compare_model();
        for (int d = 0; d < 2; d++) begin
            int a_sout, a_rdy, a_busy, a_wd, a_cnt, a_pout;
            if (d == 0) begin
                a_sout = int'(b0.serial_out); a_rdy = int'(b0.load_ready);
                a_busy = int'(b0.busy); a_wd = int'(b0.word_done);
                a_cnt = int'(b0.count); a_pout = int'(b0.parallel_out);
            end else begin
                a_sout = int'(b1.serial_out); a_rdy = int'(b1.load_ready);
                a_busy = int'(b1.busy); a_wd = int'(b1.word_done);
                a_cnt = int'(b1.count); a_pout = int'(b1.parallel_out);
            end
            chk($sformatf("m%0d_sout", d), a_sout, exp_sout(d));
            chk($sformatf("m%0d_ready", d), a_rdy, int'(exp_ready(d)));
            chk($sformatf("m%0d_busy", d), a_busy, int'(mbusy[d]));
            chk($sformatf("m%0d_word_done", d), a_wd, int'(mwd[d]));
            chk($sformatf("m%0d_count", d), a_cnt, mcnt[d]);
            chk($sformatf("m%0d_pout", d), a_pout, mv[d]);
`ifdef FLEX_SR_LANE_PARITY_EN
            chk($sformatf("m%0d_parity", d), d == 0 ? int'(b0.parity_out) : int'(b1.parity_out),
                int'(mpar[d]));
`endif
        end
    endtask

    task automatic update_model();
        for (int d = 0; d < 2; d++) begin
            int l = lanes(d);
            int n = 8 / l;
            int s = int'(sin) % (1 << l);
            int so;
            bit rdy, fin, acc, dir, npar;
            if (rst) begin
                mv[d] = 8'hFF; mbusy[d] = 0; mcnt[d] = 0;
                mwd[d] = 0; mdir[d] = 0; mpar[d] = 0;
                continue;
            end
            so  = exp_sout(d);
            rdy = exp_ready(d);
            dir = mbusy[d] ? mdir[d] : msb;
            fin = mbusy[d] && sh && (mcnt[d] == n - 1);
            acc = lv && rdy;
            if (mbusy[d] && sh)
                npar = (mwd[d] ? 1'b0 : mpar[d]) ^ 1'($countones(so) % 2);
            else if (acc || mwd[d])
                npar = 1'b0;
            else
                npar = mpar[d];
            if (acc) begin
                mv[d] = pin; mdir[d] = msb; mcnt[d] = 0; mbusy[d] = 1;
            end else begin
                if (sh)
                    mv[d] = dir ? (((mv[d] << l) | s) % 256)
                                : ((mv[d] >> l) | (s << (8 - l)));
                if (mbusy[d] && sh) begin
                    if (fin) begin mcnt[d] = 0; mbusy[d] = 0; end
                    else mcnt[d] = mcnt[d] + 1;
                end
            end
            mwd[d]  = fin;
            mpar[d] = npar;
        end
    endtask

    task automatic settle();
        drive();
        @(negedge clk);
        compare_model();
    endtask

    task automatic edge_();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cyc(input logic l, input logic [7:0] p, input logic m,
                       input logic s, input logic [1:0] si);
        lv = l; pin = p; msb = m; sh = s; sin = si;
        settle();
        edge_();
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hA5);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'h4A);
        tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'h94);
        tbl[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h28);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 8'h50);
        tbl[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'hA0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 8'h40);
        tbl[8]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 8'h80);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);

        // reset: two cycles
        rst = 1'b1; lv = 0; pin = 0; msb = 0; sh = 0; sin = 0;
        drive();
        edge_();
        settle();
        edge_();
        rst = 1'b0;
        settle();
        chk("rst_pout0", int'(b0.parallel_out), 8'hFF);
        chk("rst_pout1", int'(b1.parallel_out), 8'hFF);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_ready", int'(b0.load_ready), 1);
        chk("rst_wd", int'(b0.word_done), 0);
        chk("rst_cnt", int'(b0.count), 0);
        edge_();

        // MSB-first single lane vectors
        for (int i = 0; i < 11; i++) begin
            lv = tbl[i].lv; pin = tbl[i].pin; msb = tbl[i].msb;
            sh = tbl[i].sh; sin = {1'b0, tbl[i].sin};
            settle();
            chk($sformatf("tbl%0d_sout", i), int'(b0.serial_out), int'(tbl[i].sout));
            chk($sformatf("tbl%0d_ready", i), int'(b0.load_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_busy", i), int'(b0.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_wd", i), int'(b0.word_done), int'(tbl[i].wd));
            chk($sformatf("tbl%0d_cnt", i), int'(b0.count), int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_pout", i), int'(b0.parallel_out), int'(tbl[i].pout));
            edge_();
        end

        // two-lane LSB-first word
        cyc(1'b1, 8'h1B, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            lv = 0; msb = 0; sh = 1; sin = 2'b11;
            settle();
            chk($sformatf("lsb2_sout%0d", k), int'(b1.serial_out), 3 - k);
            chk($sformatf("lsb2_cnt%0d", k), int'(b1.count), k);
            edge_();
        end
        lv = 0; sh = 0; sin = 0;
        settle();
        chk("lsb2_pout", int'(b1.parallel_out), 8'hFF);
        chk("lsb2_cnt_wrap", int'(b1.count), 0);
        chk("lsb2_wd", int'(b1.word_done), 1);
        edge_();
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);

        // back-to-back words
        cyc(1'b1, 8'hF0, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 7; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        lv = 1; pin = 8'h0F; msb = 1; sh = 1; sin = 0;
        settle();
        chk("b2b_ready", int'(b0.load_ready), 1);
        edge_();
        lv = 0; sh = 0;
        settle();
        chk("b2b_wd", int'(b0.word_done), 1);
        chk("b2b_busy", int'(b0.busy), 1);
        chk("b2b_pout", int'(b0.parallel_out), 8'h0F);
        chk("b2b_cnt", int'(b0.count), 0);
        edge_();
        for (int k = 0; k < 8; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b01);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);

        // load refused mid-word, then stalls
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        lv = 1; pin = 8'h00; sh = 0;
        settle();
        chk("conf_ready", int'(b0.load_ready), 0);
        edge_();
        for (int k = 0; k < 3; k++) begin
            lv = 0; sh = 0;
            settle();
            chk($sformatf("stall%0d_pout", k), int'(b0.parallel_out), 8'h28);
            chk($sformatf("stall%0d_cnt", k), int'(b0.count), 3);
            edge_();
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);

        // reset abandons a word at count 5
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b10);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        settle();
        chk("rstmid_busy", int'(b0.busy), 0);
        chk("rstmid_cnt", int'(b0.count), 0);
        chk("rstmid_wd", int'(b0.word_done), 0);
        edge_();
        settle();
        chk("rstmid_wd2", int'(b0.word_done), 0);
        edge_();

`ifdef FLEX_SR_LANE_PARITY_EN
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        settle();
        chk("par_a5", int'(b0.parity_out), 0);
        edge_();
        cyc(1'b1, 8'hA4, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        lv = 0; sh = 0;
        settle();
        chk("par_a4", int'(b0.parity_out), 1);
        edge_();
`endif

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0), 2'($urandom));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
